tick_generator: RTL and testbench

//   Parametrised timebase for the kitchen timer. Divides clk_in by a runtime-loadable divisor.

---
 rtl/tick_generator_if.sv | 40 ++++
 rtl/tick_generator.sv | 116 +++++++++++
 tb/tb_tick_generator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_generator_if.sv
// Bus between the timebase and its consumers: run/clear/divisor controls
// going in, divided pulses and status coming back.
// half_tick is present only when TICKGEN_HALF_EN is defined.
interface tick_generator_if #(
    parameter int DIV_W  = 27,
    parameter int TCNT_W = 16
);
    logic              start;
    logic              clear;
    logic              div_load;
    logic [DIV_W-1:0]  div_value;
    logic [DIV_W-1:0]  div_q;
    logic              tick;
    logic              clk_out;
    logic [TCNT_W-1:0] tick_count;
    logic              refresh_tick;
`ifdef TICKGEN_HALF_EN
    logic              half_tick;

    modport master (
        output start, clear, div_load, div_value,
        input  div_q, tick, clk_out, tick_count, refresh_tick, half_tick
    );

    modport slave (
        input  start, clear, div_load, div_value,
        output div_q, tick, clk_out, tick_count, refresh_tick, half_tick
    );
`else
    modport master (
        output start, clear, div_load, div_value,
        input  div_q, tick, clk_out, tick_count, refresh_tick
    );

    modport slave (
        input  start, clear, div_load, div_value,
        output div_q, tick, clk_out, tick_count, refresh_tick
    );
`endif
endinterface

// File: rtl/tick_generator.sv
// Kitchen timer timebase: divides clk_in by a runtime-loadable divisor and
// produces a one-cycle tick, a 50% duty clk_out, a wrapping tick counter and
// a free-running display refresh pulse. Every output comes from a register.
// Optional feature macro: TICKGEN_HALF_EN adds the mid-period half_tick pulse.
module tick_generator #(
    parameter int DIV_W       = 27,
    parameter int DEFAULT_DIV = 100_000_000,
    parameter int REFRESH_DIV = 100_000,
    parameter int TCNT_W      = 16
) (
    input  logic            clk_in,
    input  logic            reset,
    tick_generator_if.slave bus
);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_clamped;
    logic              terminal;
    logic              tick;
    logic              clk_out;
    logic [TCNT_W-1:0] tick_count;
    logic [REF_W-1:0]  ref_cnt;
    logic              refresh_tick;

    // Divisors below two would make a period with no room for a pulse, so force them up to two
    always_comb begin
        div_clamped = bus.div_value;
        if (bus.div_value < MIN_DIV) begin
            div_clamped = MIN_DIV;
        end
    end

    assign terminal = (cnt == div_q - DIV_W'(1));

    // Period counter, divisor register and tick outputs; clear beats load, load beats counting
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            div_q      <= RESET_DIV;
            tick       <= 1'b0;
            clk_out    <= 1'b0;
            tick_count <= '0;
        end else if (bus.clear) begin
            cnt        <= '0;
            tick       <= 1'b0;
            clk_out    <= 1'b0;
            tick_count <= '0;
            if (bus.div_load) begin
                div_q <= div_clamped;
            end
        end else if (bus.div_load) begin
            div_q <= div_clamped;
            cnt   <= '0;
            tick  <= 1'b0;
        end else if (bus.start) begin
            if (terminal) begin
                cnt        <= '0;
                tick       <= 1'b1;
                clk_out    <= ~clk_out;
                tick_count <= tick_count + TCNT_W'(1);
            end else begin
                cnt  <= cnt + DIV_W'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Display refresh runs from reset alone so the 7-seg mux never stalls
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            ref_cnt      <= '0;
            refresh_tick <= 1'b0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt      <= '0;
            refresh_tick <= 1'b1;
        end else begin
            ref_cnt      <= ref_cnt + REF_W'(1);
            refresh_tick <= 1'b0;
        end
    end

    assign bus.div_q        = div_q;
    assign bus.tick         = tick;
    assign bus.clk_out      = clk_out;
    assign bus.tick_count   = tick_count;
    assign bus.refresh_tick = refresh_tick;

`ifdef TICKGEN_HALF_EN
    logic half_tick;
    logic mid_point;

    assign mid_point = (cnt == (div_q >> 1) - DIV_W'(1));

    // Mid-period pulse for the colon blink; clear, load and pause silence it just like tick
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            half_tick <= 1'b0;
        end else if (bus.clear || bus.div_load) begin
            half_tick <= 1'b0;
        end else if (bus.start) begin
            half_tick <= mid_point;
        end else begin
            half_tick <= 1'b0;
        end
    end

    assign bus.half_tick = half_tick;
`endif
endmodule

// File: tb/tb_tick_generator.sv
// Testbench for tick_generator with small parameters (divisor 7 after reset,
// refresh every 8 cycles, 4-bit tick counter). A behavioural model tracks
// running cycles per period and total ticks; table vectors and hand-written
// sequences cover the corner cases, then random traffic is compared to the model.
module tb_tick_generator;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 7;
    localparam int REFRESH_DIV = 8;
    localparam int TCNT_W      = 4;

    logic             clk;
    logic             reset;
    logic             start_s;
    logic             clear_s;
    logic             load_s;
    logic [DIV_W-1:0] value_s;

    int tests;
    int fails;

    int m_div;
    int m_phase;
    int m_ticks;
    int m_cycles;
    bit m_tick;
    bit m_half;

    typedef struct {
        logic             start;
        logic             clear;
        logic             load;
        logic [DIV_W-1:0] value;
        logic             exp_tick;
        logic             exp_clk;
        logic [TCNT_W-1:0] exp_count;
        logic [DIV_W-1:0] exp_divq;
    } vec_t;

    vec_t vecs[$];

    tick_generator_if #(.DIV_W(DIV_W), .TCNT_W(TCNT_W)) bus ();

    assign bus.start     = start_s;
    assign bus.clear     = clear_s;
    assign bus.div_load  = load_s;
    assign bus.div_value = value_s;

    tick_generator #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .REFRESH_DIV (REFRESH_DIV),
        .TCNT_W      (TCNT_W)
    ) dut (
        .clk_in (clk),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a stuck run still terminates with a visible reason
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampDiv(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic modelReset();
        m_div    = DEFAULT_DIV;
        m_phase  = 0;
        m_ticks  = 0;
        m_cycles = 0;
        m_tick   = 0;
        m_half   = 0;
    endtask

    // One clock edge of the reference: running cycles within the period and total tick count
    task automatic modelEdge();
        m_cycles++;
        if (clear_s) begin
            m_phase = 0;
            m_ticks = 0;
            m_tick  = 0;
            m_half  = 0;
            if (load_s) m_div = clampDiv(int'(value_s));
        end else if (load_s) begin
            m_div   = clampDiv(int'(value_s));
            m_phase = 0;
            m_tick  = 0;
            m_half  = 0;
        end else if (start_s) begin
            m_phase++;
            m_half = (m_phase == m_div / 2);
            if (m_phase == m_div) begin
                m_tick  = 1;
                m_phase = 0;
                m_ticks++;
            end else begin
                m_tick = 0;
            end
        end else begin
            m_tick = 0;
            m_half = 0;
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".tick"},       32'(bus.tick),         32'(m_tick));
        cmp({tag, ".clk_out"},    32'(bus.clk_out),      32'(m_ticks % 2));
        cmp({tag, ".tick_count"}, 32'(bus.tick_count),   32'(m_ticks % (1 << TCNT_W)));
        cmp({tag, ".div_q"},      32'(bus.div_q),        32'(m_div));
        cmp({tag, ".refresh"},    32'(bus.refresh_tick), 32'((m_cycles % REFRESH_DIV) == 0));
`ifdef TICKGEN_HALF_EN
        cmp({tag, ".half_tick"},  32'(bus.half_tick),    32'(m_half));
`endif
    endtask

    // Drive one set of inputs across one active edge, then compare just after it
    task automatic applyStimulus(input logic s, input logic c, input logic l,
                                 input int v, input string tag);
        start_s = s;
        clear_s = c;
        load_s  = l;
        value_s = DIV_W'(v);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    function automatic void addVec(input logic s, input logic c, input logic l, input int v,
                                   input logic t, input logic co, input int n, input int d);
        vec_t x;
        x.start     = s;
        x.clear     = c;
        x.load      = l;
        x.value     = DIV_W'(v);
        x.exp_tick  = t;
        x.exp_clk   = co;
        x.exp_count = TCNT_W'(n);
        x.exp_divq  = DIV_W'(d);
        vecs.push_back(x);
    endfunction

    task automatic checkResetValues(input string tag);
        cmp({tag, ".tick"},       32'(bus.tick),         0);
        cmp({tag, ".clk_out"},    32'(bus.clk_out),      0);
        cmp({tag, ".tick_count"}, 32'(bus.tick_count),   0);
        cmp({tag, ".div_q"},      32'(bus.div_q),        DEFAULT_DIV);
        cmp({tag, ".refresh"},    32'(bus.refresh_tick), 0);
`ifdef TICKGEN_HALF_EN
        cmp({tag, ".half_tick"},  32'(bus.half_tick),    0);
`endif
    endtask

    initial begin
        int pulses;
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        start_s = 1'b0;
        clear_s = 1'b0;
        load_s  = 1'b0;
        value_s = '0;
        modelReset();

        // Divisor 5 from a clean period: ticks on running cycles 5, 10, 15, 20
        addVec(0, 0, 1, 5, 0, 0, 0, 5);
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) addVec(1, 0, 0, 0, 0, g % 2, g, 5);
            addVec(1, 0, 0, 0, 1, (g + 1) % 2, g + 1, 5);
        end
        // Clear on the terminal-count edge swallows that tick; next one is 5 cycles later
        for (int k = 0; k < 4; k++) addVec(1, 0, 0, 0, 0, 0, 4, 5);
        addVec(1, 1, 0, 0, 0, 0, 0, 5);
        for (int k = 0; k < 4; k++) addVec(1, 0, 0, 0, 0, 0, 0, 5);
        addVec(1, 0, 0, 0, 1, 1, 1, 5);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkResetValues("por");

        // Reset arriving mid-count must act without waiting for an edge
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, "run7");
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkResetValues("async_reset");
        modelReset();
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].start, vecs[i].clear, vecs[i].load, int'(vecs[i].value), "table");
            cmp("table.tick",    32'(bus.tick),       32'(vecs[i].exp_tick));
            cmp("table.clk_out", 32'(bus.clk_out),    32'(vecs[i].exp_clk));
            cmp("table.count",   32'(bus.tick_count), 32'(vecs[i].exp_count));
            cmp("table.div_q",   32'(bus.div_q),      32'(vecs[i].exp_divq));
        end

        // Pause keeps the phase: 3 running, 7 paused, then the tick lands 2 running cycles later
        applyStimulus(0, 1, 1, 5, "pause_load");
        cmp("pause_load.count", 32'(bus.tick_count), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, "pause_run");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 0, 0, 0, "pause_hold");
            cmp("pause_hold.tick", 32'(bus.tick), 0);
        end
        applyStimulus(1, 0, 0, 0, "resume1");
        cmp("resume1.tick", 32'(bus.tick), 0);
        applyStimulus(1, 0, 0, 0, "resume2");
        cmp("resume2.tick",  32'(bus.tick),       1);
        cmp("resume2.count", 32'(bus.tick_count), 1);

        // Divisor values 0 and 1 both clamp to 2
        for (int v = 0; v < 2; v++) begin
            applyStimulus(0, 0, 1, v, "clamp_load");
            cmp("clamp.div_q", 32'(bus.div_q), 2);
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1, 0, 0, 0, "clamp_run");
                cmp("clamp.tick", 32'(bus.tick), 32'(i % 2));
            end
        end

        // 17 ticks on a 4-bit counter wrap through zero and read 1
        applyStimulus(0, 1, 1, 2, "wrap_load");
        for (int i = 0; i < 34; i++) applyStimulus(1, 0, 0, 0, "wrap_run");
        cmp("wrap.count", 32'(bus.tick_count), 1);

        // Refresh keeps its cadence while paused and while clear toggles
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, (i % 2) == 1, 0, 0, "refresh");
            if (bus.refresh_tick) pulses++;
        end
        cmp("refresh.pulses_in_16", 32'(pulses), 2);

`ifdef TICKGEN_HALF_EN
        // Divisor 6: half pulse on the cnt==2 edge, tick on the cnt==5 edge
        applyStimulus(0, 1, 1, 6, "half_load");
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1, 0, 0, 0, "half_run");
            cmp("half.half_tick", 32'(bus.half_tick), 32'(i == 3));
            cmp("half.tick",      32'(bus.tick),      32'(i == 6));
        end
`endif

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(3, 0) != 0,
                          $urandom_range(19, 0) == 0,
                          $urandom_range(19, 0) == 0,
                          int'($urandom_range(12, 0)),
                          "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
